// File: rtl/pio_avmm_responder.sv
// Avalon-MM burst responder backed by an on-chip 512-bit RAM; PIO target BAR memory and loop-back endpoint.
// Optional macro PIO_AVMM_RANGE_CHECK_EN: per-beat range check (out-of-range writes dropped, reads return SLVERR).
module pio_avmm_responder #(
    parameter int DEPTH     = 256,
    parameter int AW        = $clog2(DEPTH),
    parameter int MAX_BURST = 8
) (
    input  logic         Clk_i,
    input  logic         Rst_i,
    input  logic [63:0]  avs_address_i,
    input  logic         avs_read_i,
    input  logic         avs_write_i,
    input  logic [511:0] avs_writedata_i,
    input  logic [63:0]  avs_byteenable_i,
    input  logic [3:0]   avs_burstcount_i,
    output logic         avs_waitrequest_o,
    output logic [511:0] avs_readdata_o,
    output logic         avs_readdatavalid_o,
    output logic [1:0]   avs_response_o,
    output logic         busy_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } state_t;

    localparam logic [3:0] MAX_BC = 4'(MAX_BURST);

    state_t          state_r, state_s;
    logic [AW-1:0]   idx_r, idx_s;
    logic [3:0]      rem_r, rem_s;
    logic            waitrequest_r;

    logic [3:0]      bc_eff_s;
    logic [AW-1:0]   cmd_idx_s;
    logic [AW-1:0]   wr_idx_s;
    logic            cmd_wr_s;
    logic            cmd_rd_s;
    logic            we_s;
    logic            rd_issue_s;
    logic            oor_s;

    logic [511:0]    mem [DEPTH];
    logic [511:0]    ram_q_r;
    logic            v1_r;
    logic            oor1_r;
    logic            rdv_r;
    logic [511:0]    readdata_r;
    logic [1:0]      response_r;

    assign cmd_idx_s  = avs_address_i[AW+5:6];
    // Commands are only taken in IDLE while waitrequest is low; read+write together counts as a write.
    assign cmd_wr_s   = (state_r == IDLE) && !waitrequest_r && avs_write_i;
    assign cmd_rd_s   = (state_r == IDLE) && !waitrequest_r && avs_read_i && !avs_write_i;
    assign we_s       = cmd_wr_s || ((state_r == WR_BURST) && avs_write_i);
    assign wr_idx_s   = (state_r == IDLE) ? cmd_idx_s : idx_r;
    assign rd_issue_s = (state_r == RD_BURST);

    // Burstcount normalisation: 0 means one beat, oversize bursts clamp to MAX_BC.
    always_comb begin
        bc_eff_s = avs_burstcount_i;
        if (avs_burstcount_i == 4'd0) begin
            bc_eff_s = 4'd1;
        end else if (avs_burstcount_i > MAX_BC) begin
            bc_eff_s = MAX_BC;
        end else begin
            bc_eff_s = avs_burstcount_i;
        end
    end

`ifdef PIO_AVMM_RANGE_CHECK_EN
    // Full-width word address of the current beat; one extra bit so start+offset never wraps.
    logic [58:0] word_r, word_s;
    logic [58:0] cmd_word_s;
    logic [58:0] beat_word_s;

    assign cmd_word_s  = {1'b0, avs_address_i[63:6]};
    assign beat_word_s = (state_r == IDLE) ? cmd_word_s : word_r;
    assign oor_s       = (beat_word_s >= 59'(DEPTH));

    // Beat word address tracking, advancing in step with idx_r.
    always_comb begin
        word_s = word_r;
        if (cmd_wr_s) begin
            word_s = cmd_word_s + 59'd1;
        end else if (cmd_rd_s) begin
            word_s = cmd_word_s;
        end else if (rd_issue_s || ((state_r == WR_BURST) && avs_write_i)) begin
            word_s = word_r + 59'd1;
        end else begin
            word_s = word_r;
        end
    end

    // Beat word address register.
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            word_r <= 59'd0;
        end else begin
            word_r <= word_s;
        end
    end
`else
    assign oor_s = 1'b0;
`endif

    // Next-state, beat index and remaining-beat computation.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        rem_s   = rem_r;
        case (state_r)
            IDLE: begin
                if (cmd_wr_s) begin
                    idx_s = cmd_idx_s + AW'(1'b1);
                    rem_s = bc_eff_s - 4'd1;
                    if (bc_eff_s > 4'd1) begin
                        state_s = WR_BURST;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (cmd_rd_s) begin
                    idx_s   = cmd_idx_s;
                    rem_s   = bc_eff_s;
                    state_s = RD_BURST;
                end else begin
                    state_s = IDLE;
                end
            end
            WR_BURST: begin
                if (avs_write_i) begin
                    idx_s = idx_r + AW'(1'b1);
                    rem_s = rem_r - 4'd1;
                    if (rem_r == 4'd1) begin
                        state_s = IDLE;
                    end else begin
                        state_s = WR_BURST;
                    end
                end else begin
                    state_s = WR_BURST;
                end
            end
            RD_BURST: begin
                idx_s = idx_r + AW'(1'b1);
                rem_s = rem_r - 4'd1;
                if (rem_r == 4'd1) begin
                    state_s = IDLE;
                end else begin
                    state_s = RD_BURST;
                end
            end
            default: begin
                state_s = IDLE;
                idx_s   = idx_r;
                rem_s   = rem_r;
            end
        endcase
    end

    // FSM state register; waitrequest is registered and high exactly while reading.
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            state_r       <= IDLE;
            idx_r         <= {AW{1'b0}};
            rem_r         <= 4'd0;
            waitrequest_r <= 1'b1;
        end else begin
            state_r       <= state_s;
            idx_r         <= idx_s;
            rem_r         <= rem_s;
            waitrequest_r <= (state_s == RD_BURST);
        end
    end

    // RAM array: byte-lane writes and a registered read port (read-during-write returns old data).
    always_ff @(posedge Clk_i) begin
        if (we_s && !oor_s && !Rst_i) begin
            for (int b = 0; b < 64; b++) begin
                if (avs_byteenable_i[b]) begin
                    mem[wr_idx_s][b*8 +: 8] <= avs_writedata_i[b*8 +: 8];
                end
            end
        end
        ram_q_r <= mem[idx_r];
    end

    // Two-stage read return pipeline: RAM output stage then output register.
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            v1_r       <= 1'b0;
            oor1_r     <= 1'b0;
            rdv_r      <= 1'b0;
            readdata_r <= {512{1'b0}};
            response_r <= 2'b00;
        end else begin
            v1_r       <= rd_issue_s;
            oor1_r     <= rd_issue_s && oor_s;
            rdv_r      <= v1_r;
            readdata_r <= oor1_r ? {512{1'b0}} : ram_q_r;
            response_r <= oor1_r ? 2'b10 : 2'b00;
        end
    end

    assign avs_waitrequest_o   = waitrequest_r;
    assign avs_readdata_o      = readdata_r;
    assign avs_readdatavalid_o = rdv_r;
    assign avs_response_o      = response_r;
    assign busy_o              = (state_r != IDLE) || v1_r || rdv_r;

endmodule

// File: tb/tb_pio_avmm_responder.sv
// Directed self-checking bench for pio_avmm_responder (DEPTH=256, MAX_BURST=8).
module tb_pio_avmm_responder;

    logic         Clk_i;
    logic         Rst_i;
    logic [63:0]  avs_address_i;
    logic         avs_read_i;
    logic         avs_write_i;
    logic [511:0] avs_writedata_i;
    logic [63:0]  avs_byteenable_i;
    logic [3:0]   avs_burstcount_i;
    logic         avs_waitrequest_o;
    logic [511:0] avs_readdata_o;
    logic         avs_readdatavalid_o;
    logic [1:0]   avs_response_o;
    logic         busy_o;

    int n_assert = 0;
    int n_fail   = 0;

    logic [511:0] got_data [16];
    logic [1:0]   got_rsp  [16];
    int           got_off  [16];
    logic         wr_hist  [25];
    int           n_beats;

    logic [511:0] pat_a, d0, d1, d2, d3, e0, e1, exp_idx0, part_val;
    int           stray;

    pio_avmm_responder #(.DEPTH(256), .MAX_BURST(8)) dut (
        .Clk_i               (Clk_i),
        .Rst_i               (Rst_i),
        .avs_address_i       (avs_address_i),
        .avs_read_i          (avs_read_i),
        .avs_write_i         (avs_write_i),
        .avs_writedata_i     (avs_writedata_i),
        .avs_byteenable_i    (avs_byteenable_i),
        .avs_burstcount_i    (avs_burstcount_i),
        .avs_waitrequest_o   (avs_waitrequest_o),
        .avs_readdata_o      (avs_readdata_o),
        .avs_readdatavalid_o (avs_readdatavalid_o),
        .avs_response_o      (avs_response_o),
        .busy_o              (busy_o)
    );

    initial Clk_i = 1'b0;
    always #5 Clk_i = ~Clk_i;

    function automatic logic [511:0] pat(input logic [31:0] seed);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = seed * 32'h9E37_79B1 + 32'(i);
        return r;
    endfunction

    task automatic tick;
        @(posedge Clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready;
        for (int i = 0; i < 50; i++) begin
            if (avs_waitrequest_o === 1'b0) break;
            tick;
        end
        check("wait_ready", 512'(avs_waitrequest_o), 512'd0);
    endtask

    task automatic write_cmd(input logic [63:0] addr, input logic [3:0] bc,
                             input logic [511:0] data, input logic [63:0] be);
        wait_ready;
        avs_address_i    = addr;
        avs_burstcount_i = bc;
        avs_writedata_i  = data;
        avs_byteenable_i = be;
        avs_write_i      = 1'b1;
        tick;
        avs_write_i      = 1'b0;
    endtask

    task automatic write_beat(input logic [511:0] data);
        avs_address_i   = 64'hDEAD_BEEF_0000_0000;
        avs_writedata_i = data;
        avs_write_i     = 1'b1;
        tick;
        avs_write_i     = 1'b0;
    endtask

    // Issue a read, then log waitrequest and every returned beat for 24 cycles.
    task automatic do_read(input logic [63:0] addr, input logic [3:0] bc);
        wait_ready;
        avs_address_i    = addr;
        avs_burstcount_i = bc;
        avs_read_i       = 1'b1;
        tick;
        avs_read_i       = 1'b0;
        n_beats          = 0;
        for (int k = 1; k < 25; k++) begin
            wr_hist[k] = avs_waitrequest_o;
            if (avs_readdatavalid_o === 1'b1 && n_beats < 16) begin
                got_data[n_beats] = avs_readdata_o;
                got_rsp[n_beats]  = avs_response_o;
                got_off[n_beats]  = k;
                n_beats++;
            end
            tick;
        end
    endtask

    initial begin
        pat_a = pat(32'd1);
        d0 = pat(32'd10); d1 = pat(32'd11); d2 = pat(32'd12); d3 = pat(32'd13);
        e0 = pat(32'd20); e1 = pat(32'd21);
        part_val = {{60{8'hFF}}, 32'h0000_0000};

        Rst_i = 1'b1;
        avs_address_i = 64'd0; avs_read_i = 1'b0; avs_write_i = 1'b0;
        avs_writedata_i = {512{1'b0}}; avs_byteenable_i = 64'd0; avs_burstcount_i = 4'd1;
        tick; tick;
        check("rst_waitrequest", 512'(avs_waitrequest_o), 512'd1);
        check("rst_rdv", 512'(avs_readdatavalid_o), 512'd0);
        check("rst_readdata", avs_readdata_o, 512'd0);
        check("rst_response", 512'(avs_response_o), 512'd0);
        check("rst_busy", 512'(busy_o), 512'd0);
        Rst_i = 1'b0;
        tick;
        check("post_rst_waitrequest", 512'(avs_waitrequest_o), 512'd0);

        // Single write then read, latency 3 from accept.
        write_cmd(64'h40, 4'd1, pat_a, 64'hFFFF_FFFF_FFFF_FFFF);
        do_read(64'h40, 4'd1);
        check("single_nbeats", 512'(n_beats), 512'd1);
        check("single_data", got_data[0], pat_a);
        check("single_rsp", 512'(got_rsp[0]), 512'd0);
        check("single_latency", 512'(got_off[0]), 512'd3);

        // Burst write of 4 with an idle cycle after beat 1.
        write_cmd(64'h100, 4'd4, d0, 64'hFFFF_FFFF_FFFF_FFFF);
        write_beat(d1);
        check("wrburst_idle_wait", 512'(avs_waitrequest_o), 512'd0);
        check("wrburst_idle_busy", 512'(busy_o), 512'd1);
        tick;
        write_beat(d2);
        write_beat(d3);
        check("wrburst_done_busy", 512'(busy_o), 512'd0);
        do_read(64'h100, 4'd4);
        check("burst_nbeats", 512'(n_beats), 512'd4);
        check("burst_d0", got_data[0], d0);
        check("burst_d1", got_data[1], d1);
        check("burst_d2", got_data[2], d2);
        check("burst_d3", got_data[3], d3);
        check("burst_first_off", 512'(got_off[0]), 512'd3);
        check("burst_last_off", 512'(got_off[3]), 512'd6);
        check("burst_wr_k1", 512'(wr_hist[1]), 512'd1);
        check("burst_wr_k4", 512'(wr_hist[4]), 512'd1);
        check("burst_wr_k5", 512'(wr_hist[5]), 512'd0);

        // Partial byteenable.
        write_cmd(64'h0, 4'd1, {64{8'hFF}}, 64'hFFFF_FFFF_FFFF_FFFF);
        write_cmd(64'h0, 4'd1, {512{1'b0}}, 64'h0000_0000_0000_000F);
        do_read(64'h0, 4'd1);
        check("partial_be", got_data[0], part_val);

        // Wrap at index 255 and burstcount 0.
        write_cmd(64'h3FC0, 4'd2, e0, 64'hFFFF_FFFF_FFFF_FFFF);
        write_beat(e1);
`ifdef PIO_AVMM_RANGE_CHECK_EN
        exp_idx0 = part_val;
`else
        exp_idx0 = e1;
`endif
        do_read(64'h0, 4'd0);
        check("bc0_nbeats", 512'(n_beats), 512'd1);
        check("wrap_idx0", got_data[0], exp_idx0);
        do_read(64'h3FC0, 4'd2);
        check("edge_nbeats", 512'(n_beats), 512'd2);
        check("edge_b0_data", got_data[0], e0);
        check("edge_b0_rsp", 512'(got_rsp[0]), 512'd0);
`ifdef PIO_AVMM_RANGE_CHECK_EN
        check("range_b1_data", got_data[1], 512'd0);
        check("range_b1_rsp", 512'(got_rsp[1]), 512'd2);
        write_cmd(64'h4000, 4'd1, pat(32'd99), 64'hFFFF_FFFF_FFFF_FFFF);
        do_read(64'h0, 4'd1);
        check("range_wr_dropped", got_data[0], part_val);
`else
        check("wrap_b1_data", got_data[1], e1);
        check("wrap_b1_rsp", 512'(got_rsp[1]), 512'd0);
        do_read(64'h0000_0001_0000_0040, 4'd1);
        check("upper_bits_ignored", got_data[0], pat_a);
`endif

        // Burstcount above MAX_BURST clamps to 8.
        do_read(64'h0, 4'd15);
        check("clamp_nbeats", 512'(n_beats), 512'd8);
        check("clamp_last_off", 512'(got_off[7]), 512'd10);
        check("clamp_wr_k8", 512'(wr_hist[8]), 512'd1);
        check("clamp_wr_k9", 512'(wr_hist[9]), 512'd0);

        // Reset during the third issue cycle of an 8-beat read.
        wait_ready;
        avs_address_i = 64'h100; avs_burstcount_i = 4'd8; avs_read_i = 1'b1;
        tick;
        avs_read_i = 1'b0;
        tick;
        tick;
        check("rstmid_beat0_valid", 512'(avs_readdatavalid_o), 512'd1);
        check("rstmid_beat0_data", avs_readdata_o, d0);
        Rst_i = 1'b1;
        tick;
        Rst_i = 1'b0;
        check("rstmid_wr_in_rst", 512'(avs_waitrequest_o), 512'd1);
        check("rstmid_rdv", 512'(avs_readdatavalid_o), 512'd0);
        check("rstmid_busy", 512'(busy_o), 512'd0);
        tick;
        check("rstmid_wr_after", 512'(avs_waitrequest_o), 512'd0);
        stray = 0;
        for (int k = 0; k < 12; k++) begin
            if (avs_readdatavalid_o !== 1'b0) stray++;
            tick;
        end
        check("rstmid_no_stray_beats", 512'(stray), 512'd0);
        check("rstmid_busy_end", 512'(busy_o), 512'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pio_avmm_responder.md
Name: pio_avmm_responder

Overview:
- Avalon-MM burst slave at the far end of the PCIe PIO master interface.
- Decodes read and write commands (64-bit byte address, 512-bit data, burstcount up to 8) into an on-chip RAM.
- Returns readdata, readdatavalid and response beats.
- Used as the default PIO target BAR memory in the system and as the loop-back endpoint for PIO bring-up.

Parameters:
- DEPTH, 256, number of 512-bit words in the RAM; power of two, at least 2.
- AW, $clog2(DEPTH), word-index width (derived; do not override).
- MAX_BURST, 8, largest legal burstcount; values above it are clamped to MAX_BURST.

Ports:
- Clk_i  in  1  clock
- Rst_i  in  1  synchronous active-high reset
- avs_address_i  in  64  byte address; bits [5:0] ignored
- avs_read_i  in  1  read command
- avs_write_i  in  1  write command / write beat
- avs_writedata_i  in  512  write data
- avs_byteenable_i  in  64  per-byte write enable
- avs_burstcount_i  in  4  beats in burst; 0 treated as 1
- avs_waitrequest_o  out  1  command/beat not accepted this cycle
- avs_readdata_o  out  512  read data
- avs_readdatavalid_o  out  1  readdata beat valid
- avs_response_o  out  2  00 OKAY, 10 SLVERR; qualified by readdatavalid
- busy_o  out  1  FSM not IDLE or read pipeline non-empty

Behaviour:
- One clock; reset is synchronous and active-high: Clk_i, Rst_i.
- Reset values: waitrequest=1, readdatavalid=0, readdata=0, response=00, busy=0, FSM=IDLE, read pipeline cleared. RAM contents are not cleared.
- Word index = avs_address_i[AW+5:6]. Bursts increment the index by 1 per beat. The index wraps modulo DEPTH, including mid-burst.
- waitrequest is registered:
  - 0 in IDLE and WR_BURST.
  - 1 in RD_BURST and during reset.
- IDLE:
  - write & !waitrequest: write beat 0 (byte lanes per byteenable). If burstcount>1, latch remaining=bc-1 and addr+1, go to WR_BURST.
  - read & !waitrequest: latch addr and bc, go to RD_BURST.
  - read and write asserted together is illegal. The block treats it as a write.
- WR_BURST:
  - Each cycle with write=1 stores one beat at the current index; address input is ignored.
  - Cycles with write=0 are idle and hold state.
  - After the last beat, go to IDLE.
- RD_BURST:
  - Issues one RAM read per cycle, with no gaps, for bc beats.
  - waitrequest deasserts the cycle after the last issue. That cycle returns to IDLE, so a new command can be accepted then.
- Read latency: readdatavalid asserts exactly 2 cycles after the issue cycle (RAM register plus output register).
  - Burst of N from command accept cycle T produces beats at T+3..T+2+N, assuming the RD_BURST entry at T+1.
  - No backpressure on readdata.
- Read-during-write to the same word returns the old data.
- Reset mid-operation: FSM to IDLE immediately. In-flight readdatavalid beats are dropped. Partially written bursts keep the beats already stored.
- busy_o = (state!=IDLE) | any pipeline valid bit.

Optional Feature:
- Macro: PIO_AVMM_RANGE_CHECK_EN.
- Defined:
  - A beat whose byte address >= DEPTH*64 is out of range, checked per beat (burst start address plus beat offset, computed at 64-bit width with no wrap).
  - Out-of-range write beats are dropped.
  - Out-of-range read beats return readdata=0 and response=10.
  - In-range beats in the same burst behave normally.
- Undefined:
  - Upper address bits are ignored, index wraps, response is always 00.

Test Plan:
- Single write then read:
  - Stimulus: write addr 0x40, data pattern A, be all-ones, bc=1; then read addr 0x40, bc=1.
  - Response: readdata=A, response=00, readdatavalid exactly 3 cycles after the read-accept cycle.
- Burst write then read-back:
  - Stimulus: burst write bc=4 at 0x100 with beats D0..D3 and one idle cycle inserted after beat 1; then burst read bc=4 at 0x100.
  - Response: D0..D3 on 4 consecutive valid cycles; waitrequest high for 4 cycles after the read accept.
- Partial byteenable:
  - Stimulus: write all-0xFF to 0x0, then write 0x00 with be=0x0000_0000_0000_000F, then read 0x0.
  - Response: bytes 0-3 = 00, all other bytes FF.
- Wrap and burstcount 0 (DEPTH=256):
  - Stimulus: burst write bc=2 at 0x3FC0 (index 255), then read bc=0 at 0x0.
  - Response: beat 1 lands at index 0; the bc=0 read returns exactly one beat.
- Reset mid-burst:
  - Stimulus: issue read bc=8; assert Rst_i in the 3rd issue cycle for 1 cycle.
  - Response: no readdatavalid after reset; waitrequest=1 during reset, 0 the following cycle; busy_o=0.
- With PIO_AVMM_RANGE_CHECK_EN:
  - Stimulus: burst read bc=2 at 0x3FC0.
  - Response: beat 0 is RAM data with response 00; beat 1 is data 0 with response 10. A write at 0x4000 leaves index 0 unchanged.
